// File: rtl/rs485_pkg.sv
// Shared types and constants for the rs485_master bus master.
// Optional even-parity framing is enabled with the RS485_PARITY_EN macro.
package rs485_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TX    = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    RX    = 3'd4
  } state_t;

  localparam int unsigned DATA_BITS = 32'd8;

`ifdef RS485_PARITY_EN
  localparam int unsigned FRAME_BITS = 32'd11;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  localparam int unsigned FRAME_BITS = 32'd10;
`endif

  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/rs485_baud_cnt.sv
// Bit-period counter shared by the TX, GUARD and RX phases; emits
// mid-bit and end-of-bit strobes while enabled.
module rs485_baud_cnt #(
  parameter int unsigned BAUD_CNT_MAX = 32'd5208
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic restart,
  input  logic en,
  output logic bit_mid,
  output logic bit_end
);

  localparam int unsigned CW = (BAUD_CNT_MAX > 32'd1) ? $clog2(BAUD_CNT_MAX) : 32'd1;
  localparam logic [CW-1:0] MID_VAL = CW'(BAUD_CNT_MAX / 32'd2 - 32'd1);
  localparam logic [CW-1:0] END_VAL = CW'(BAUD_CNT_MAX - 32'd1);

  logic [CW-1:0] r_cnt;

  // wrapping bit-period counter, forced to zero on each state entry
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == END_VAL) ? '0 : r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign bit_mid = en & (r_cnt == MID_VAL);
  assign bit_end = en & (r_cnt == END_VAL);

endmodule

// File: rtl/rs485_master.sv
// Half-duplex RS485 master: sends one request frame, releases the bus, then
// waits for one response byte or a timeout. Optional macro: RS485_PARITY_EN.
module rs485_master
  import rs485_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 32'd50_000_000,
  parameter int unsigned UART_BPS     = 32'd9600,
  parameter int unsigned GUARD_BITS   = 32'd1,
  parameter int unsigned TIMEOUT_BITS = 32'd20
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [DATA_BITS-1:0] req_data,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 rx,
  output logic                 tx,
  output logic                 work_en,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 rsp_valid,
  output logic                 rsp_frame_err,
  output logic                 rsp_timeout,
  output logic                 busy
);

  localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_BITS * BAUD_CNT_MAX - 32'd1);
  localparam int unsigned TXS_W = FRAME_BITS - 32'd1;

  state_t               r_state;
  state_t               w_next;
  logic                 r_rx_s1, r_rx_s2, r_rx_d;
  logic                 r_tx, r_work_en, r_busy, r_req_ready;
  logic [TXS_W-1:0]     r_tx_shift;
  logic [7:0]           r_bit_idx;
  logic [31:0]          r_to_cnt;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [DATA_BITS-1:0] r_rsp_data;
  logic                 r_rsp_valid, r_rsp_ferr, r_rsp_timeout;
`ifdef RS485_PARITY_EN
  logic                 r_rx_par;
`endif
  logic                 w_fall, w_bit_mid, w_bit_end, w_restart, w_baud_en;
  logic                 w_frame_last, w_guard_last;

  assign w_fall       = r_rx_d & ~r_rx_s2;
  assign w_frame_last = (r_bit_idx == 8'(FRAME_BITS - 32'd1));
  assign w_guard_last = (r_bit_idx == 8'(GUARD_BITS - 32'd1));
  assign w_restart    = (w_next != r_state);
  assign w_baud_en    = (r_state == TX) | (r_state == GUARD) | (r_state == RX);

  rs485_baud_cnt #(.BAUD_CNT_MAX(BAUD_CNT_MAX)) u_baud (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .restart (w_restart),
    .en      (w_baud_en),
    .bit_mid (w_bit_mid),
    .bit_end (w_bit_end)
  );

  // state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // next-state logic; a start edge wins over a simultaneous timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (req_valid && r_req_ready) w_next = TX; else w_next = IDLE;
      TX:    if (w_bit_end && w_frame_last) w_next = (GUARD_BITS == 32'd0) ? WAIT : GUARD;
             else w_next = TX;
      GUARD: if (w_bit_end && w_guard_last) w_next = WAIT; else w_next = GUARD;
      WAIT:  if (w_fall) w_next = RX;
             else if (r_to_cnt >= TO_LAST) w_next = IDLE;
             else w_next = WAIT;
      RX: begin
        if (w_bit_mid && (r_bit_idx == 8'd0) && r_rx_s2) w_next = WAIT;
        else if (w_bit_mid && w_frame_last) w_next = IDLE;
        else w_next = RX;
      end
      default: w_next = IDLE;
    endcase
  end

  // datapath: synchroniser, serialiser, deserialiser, timeout and outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rx_s1 <= 1'b1;  r_rx_s2 <= 1'b1;  r_rx_d <= 1'b1;
      r_tx <= 1'b1;  r_work_en <= 1'b0;  r_busy <= 1'b0;  r_req_ready <= 1'b1;
      r_tx_shift <= '1;  r_bit_idx <= 8'd0;  r_to_cnt <= 32'd0;
      r_rx_shift <= '0;  r_rsp_data <= '0;
      r_rsp_valid <= 1'b0;  r_rsp_ferr <= 1'b0;  r_rsp_timeout <= 1'b0;
`ifdef RS485_PARITY_EN
      r_rx_par <= 1'b0;
`endif
    end else begin
      r_rx_s1       <= rx;
      r_rx_s2       <= r_rx_s1;
      r_rx_d        <= r_rx_s2;
      r_busy        <= (w_next != IDLE);
      r_req_ready   <= (w_next == IDLE);
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      case (r_state)
        IDLE: if (w_next == TX) begin
          r_tx      <= 1'b0;
          r_work_en <= 1'b1;
          r_bit_idx <= 8'd0;
`ifdef RS485_PARITY_EN
          r_tx_shift <= {1'b1, even_parity(req_data), req_data};
`else
          r_tx_shift <= {1'b1, req_data};
`endif
        end
        TX: if (w_bit_end) begin
          if (w_frame_last) begin
            r_tx      <= 1'b1;
            r_bit_idx <= 8'd0;
            if (w_next == WAIT) begin
              r_work_en <= 1'b0;
              r_to_cnt  <= 32'd0;
            end
          end else begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b1, r_tx_shift[TXS_W-1:1]};
            r_bit_idx  <= r_bit_idx + 8'd1;
          end
        end
        GUARD: if (w_bit_end) begin
          if (w_guard_last) begin
            r_work_en <= 1'b0;
            r_to_cnt  <= 32'd0;
            r_bit_idx <= 8'd0;
          end else begin
            r_bit_idx <= r_bit_idx + 8'd1;
          end
        end
        WAIT: begin
          r_to_cnt  <= r_to_cnt + 32'd1;
          r_bit_idx <= 8'd0;
          if (w_next == IDLE) r_rsp_timeout <= 1'b1;
        end
        RX: begin
          // the timeout deadline keeps running through a false start
          r_to_cnt <= r_to_cnt + 32'd1;
          if (w_bit_mid) begin
            if (w_next == WAIT) begin
              r_bit_idx <= 8'd0;
            end else if (w_frame_last) begin
              r_rsp_data  <= r_rx_shift;
              r_rsp_valid <= 1'b1;
`ifdef RS485_PARITY_EN
              r_rsp_ferr <= ~r_rx_s2 | (r_rx_par ^ even_parity(r_rx_shift));
`else
              r_rsp_ferr <= ~r_rx_s2;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 8'd1;
              if ((r_bit_idx != 8'd0) && (r_bit_idx <= 8'(DATA_BITS)))
                r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
`ifdef RS485_PARITY_EN
              else if (r_bit_idx == 8'(DATA_BITS + 32'd1))
                r_rx_par <= r_rx_s2;
`endif
            end
          end
        end
        default: r_bit_idx <= 8'd0;
      endcase
    end
  end

  assign tx            = r_tx;
  assign work_en       = r_work_en;
  assign busy          = r_busy;
  assign req_ready     = r_req_ready;
  assign rsp_data      = r_rsp_data;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_frame_err = r_rsp_ferr;
  assign rsp_timeout   = r_rsp_timeout;

endmodule

// File: tb/tb_rs485_master.sv
// Scoreboard bench for rs485_master: a frame-level model queues the expected
// line bits and responses; independent monitors pop and compare.
module tb_rs485_master;

  localparam int CLKF = 1_000_000;
  localparam int BPS  = 62_500;
  localparam int M    = CLKF / BPS;
  localparam int GB   = 1;
  localparam int TOB  = 20;
`ifdef RS485_PARITY_EN
  localparam int FB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int FB  = 10;
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    bit         is_to;
    logic [7:0] data;
    bit         ferr;
    int         cyc;
  } rsp_t;

  logic       sys_clk, sys_rst, req_valid, rx_drv;
  logic [7:0] req_data, rsp_data;
  logic       req_ready, tx, work_en, rsp_valid, rsp_frame_err, rsp_timeout, busy;
  wire        w_rx = rx_drv & tx;

  logic [10:0] q_tx[$];
  rsp_t        q_rsp[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;

  rs485_master #(.CLK_FREQ(CLKF), .UART_BPS(BPS), .GUARD_BITS(GB), .TIMEOUT_BITS(TOB)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .rx(w_rx), .tx(tx), .work_en(work_en), .rsp_data(rsp_data),
    .rsp_valid(rsp_valid), .rsp_frame_err(rsp_frame_err), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Line-level frame: start 0, data LSB first, optional even parity, stop.
  function automatic logic [10:0] build_frame(input logic [7:0] d, input bit stop, input bit pbad);
    logic [10:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    if (PAR) begin
      b[9]  = (^d) ^ pbad;
      b[10] = stop;
    end else begin
      b[9] = stop;
    end
    return b;
  endfunction

  // TX monitor: each work_en rise must carry the next expected frame.
  initial begin : tx_mon
    logic        prev_we;
    logic [10:0] fr;
    int          c;
    bit          ab;
    prev_we = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && work_en && !prev_we) begin
        chk("tx_frame_expected", 32'(q_tx.size() > 0), 32'd1);
        if (q_tx.size() > 0) fr = q_tx.pop_front();
        else fr = '1;
        c = 0;
        ab = 1'b0;
        while (1'b1) begin
          if (sys_rst) begin ab = 1'b1; break; end
          if (!work_en) break;
          if ((c % M) == M / 2 && (c / M) < FB)
            chk($sformatf("tx_bit%0d", c / M), 32'(tx), 32'(fr[c / M]));
          c++;
          if (c > (FB + GB + 2) * M) begin
            chk("tx_work_en_bound", 32'(c), 32'((FB + GB) * M));
            ab = 1'b1;
            break;
          end
          @(negedge sys_clk);
        end
        if (!ab) chk("tx_work_en_len", 32'(c), 32'((FB + GB) * M));
      end
      prev_we = work_en;
    end
  end

  // Response monitor: every rsp_valid / rsp_timeout pops one expectation.
  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && (rsp_valid || rsp_timeout)) begin
        chk("rsp_expected", 32'(q_rsp.size() > 0), 32'd1);
        if (q_rsp.size() > 0) begin
          e = q_rsp.pop_front();
          chk("rsp_timeout_flag", 32'(rsp_timeout), 32'(e.is_to));
          chk("rsp_valid_flag", 32'(rsp_valid), 32'(!e.is_to));
          if (e.is_to) begin
            chk("timeout_cycle", 32'(cyc), 32'(e.cyc));
          end else begin
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_frame_err", 32'(rsp_frame_err), 32'(e.ferr));
          end
          chk("busy_at_rsp", 32'(busy), 32'd0);
          chk("ready_at_rsp", 32'(req_ready), 32'd1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit stop, input bit pbad);
    logic [10:0] b;
    b = build_frame(d, stop, pbad);
    for (int i = 0; i < FB; i++) begin
      rx_drv = b[i];
      repeat (M) @(negedge sys_clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge sys_clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic accept(input logic [7:0] d);
    q_tx.push_back(build_frame(d, 1'b1, 1'b0));
    @(negedge sys_clk);
    req_data  = d;
    req_valid = 1'b1;
    @(negedge sys_clk);
    req_valid = 1'b0;
    chk("ready_low_in_txn", 32'(req_ready), 32'd0);
    chk("busy_in_txn", 32'(busy), 32'd1);
  endtask

  // mode 0: response; 1: timeout; 2: glitch then response; 3: glitch then timeout
  task automatic do_txn(input logic [7:0] d, input int mode, input logic [7:0] rd,
                        input bit stop, input bit pbad, input int dly);
    rsp_t e;
    int   n, tf, g;
    accept(d);
    @(negedge sys_clk);
    req_data  = 8'($urandom);
    req_valid = 1'b1;
    @(negedge sys_clk);
    req_valid = 1'b0;
    n = 0;
    while (work_en && n < 2 * FB * M) begin
      @(negedge sys_clk);
      n++;
    end
    chk("work_en_fell", 32'(work_en), 32'd0);
    tf = cyc;
    if (mode == 1 || mode == 3) begin
      e.is_to = 1'b1; e.data = 8'd0; e.ferr = 1'b0; e.cyc = tf + TOB * M;
      q_rsp.push_back(e);
    end
    if (mode >= 2) begin
      repeat (M) @(negedge sys_clk);
      g = $urandom_range(2, M / 2 - 4);
      rx_drv = 1'b0;
      repeat (g) @(negedge sys_clk);
      rx_drv = 1'b1;
      repeat (2 * M) @(negedge sys_clk);
    end
    if (mode == 0 || mode == 2) begin
      repeat (dly * M) @(negedge sys_clk);
      e.is_to = 1'b0; e.data = rd; e.ferr = !stop || (PAR && pbad); e.cyc = 0;
      q_rsp.push_back(e);
      send_byte(rd, stop, pbad);
    end
    wait_idle(TOB * M + 4 * M);
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic mid_tx_reset(input logic [7:0] d);
    accept(d);
    repeat (4 * M + M / 2 - 1) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_tx_high", 32'(tx), 32'd1);
    chk("rst_work_en_low", 32'(work_en), 32'd0);
    chk("rst_busy_low", 32'(busy), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin : main
    int m, dly;
    bit st, pb;
    sys_rst   = 1'b0;
    req_valid = 1'b0;
    req_data  = 8'd0;
    rx_drv    = 1'b1;
    #2 sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_work_en", 32'(work_en), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_frame_err", 32'(rsp_frame_err), 32'd0);
    chk("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    do_txn(8'hA5, 0, 8'h3C, 1'b1, 1'b0, 2);
    do_txn(8'h12, 1, 8'h00, 1'b1, 1'b0, 1);
    do_txn(8'h33, 0, 8'h55, 1'b0, 1'b0, 3);
    do_txn(8'h44, 0, 8'h01, 1'b1, 1'b0, 1);
    do_txn(8'h66, 2, 8'hF0, 1'b1, 1'b0, 2);
    do_txn(8'h77, 3, 8'h00, 1'b1, 1'b0, 1);
    mid_tx_reset(8'hC3);
    do_txn(8'h0F, 0, 8'h9A, 1'b1, 1'b0, 2);
    do_txn(8'h07, 0, 8'h5B, 1'b1, 1'b1, 2);
    do_txn(8'h81, 0, 8'h18, 1'b1, 1'b0, 1);

    for (int i = 0; i < 10; i++) begin
      m   = $urandom_range(0, 3);
      dly = $urandom_range(1, 6);
      st  = ($urandom_range(0, 3) != 0);
      pb  = ($urandom_range(0, 3) == 0);
      do_txn(8'($urandom), m, 8'($urandom), st, pb, dly);
    end

    repeat (20) @(negedge sys_clk);
    chk("tx_queue_drained", 32'(q_tx.size()), 32'd0);
    chk("rsp_queue_drained", 32'(q_rsp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
